// File: rtl/input_debouncer.sv
// Per-bit debouncer: two-flop synchronizer followed by a stability counter.
// level_o flips only after sync2 has disagreed with it for DebounceCycles consecutive edges.
module input_debouncer #(
    parameter int Width          = 8,
    parameter int DebounceCycles = 250000
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] raw_i,
    output logic [Width-1:0] level_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic             change_o
);

    localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [Width-1:0] sync1;
    logic [Width-1:0] sync2;
    logic [CntW-1:0]  cnt [Width];
    state_t           state [Width];
    logic [Width-1:0] flip;

    // A bit is pending whenever the synchronized input disagrees with the
    // debounced level; it flips when the window has been fully observed.
    always_comb begin
        for (int i = 0; i < Width; i++) begin
            state[i] = (sync2[i] != level_o[i]) ? PENDING : STABLE;
            flip[i]  = (state[i] == PENDING) && (cnt[i] == CntLast);
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            sync1    <= '0;
            sync2    <= '0;
            level_o  <= '0;
            rise_o   <= '0;
            fall_o   <= '0;
            change_o <= 1'b0;
            for (int i = 0; i < Width; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw_i;
            sync2    <= sync1;
            level_o  <= level_o ^ flip;
            rise_o   <= flip & ~level_o;
            fall_o   <= flip & level_o;
            change_o <= |flip;
            // Counter stops at CntLast because reaching it always flips the bit.
            for (int i = 0; i < Width; i++) begin
                if (state[i] == STABLE || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CntW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer (Width=2, DebounceCycles=4): directed scenarios plus
// random bouncing stimulus, checked per cycle against a window-based reference model.
module tb_input_debouncer;

    localparam int W  = 2;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] raw;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         change;

    logic [3*W:0] exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    string        phase    = "reset";

    // Reference state: input delay line, history of synchronized values, level.
    logic [W-1:0] d0, d1, m_level;
    logic [W-1:0] s_hist[$];

    input_debouncer #(
        .Width(W),
        .DebounceCycles(DC)
    ) dut (
        .clk_sys_i (clk),
        .rst_sys_ni(rst_n),
        .raw_i     (raw),
        .level_o   (level),
        .rise_o    (rise),
        .fall_o    (fall),
        .change_o  (change)
    );

    // Clock and initial input levels.
    always #5 clk = ~clk;

    initial begin
        rst_n = 1'b0;
        raw   = '0;
    end

    // Reference: a bit flips at an edge when the last DC synchronized samples
    // (raw delayed by two edges) all disagree with the current level.
    task automatic model_edge(input logic [W-1:0] r, input logic rn);
        logic [W-1:0] s;
        logic [W-1:0] flip;
        logic [W-1:0] old_level;
        if (!rn) begin
            d0      = '0;
            d1      = '0;
            m_level = '0;
            s_hist.delete();
            exp_q.push_back('0);
            return;
        end
        s  = d1;
        d1 = d0;
        d0 = r;
        s_hist.push_front(s);
        if (s_hist.size() > DC) void'(s_hist.pop_back());
        flip = '0;
        for (int b = 0; b < W; b++) begin
            if (s_hist.size() == DC) begin
                flip[b] = 1'b1;
                for (int k = 0; k < DC; k++) begin
                    if (s_hist[k][b] == m_level[b]) flip[b] = 1'b0;
                end
            end
        end
        old_level = m_level;
        m_level   = m_level ^ flip;
        exp_q.push_back({m_level, flip & ~old_level, flip & old_level, |flip});
    endtask

    // Driver: apply inputs, let one edge happen, record the expected response.
    task automatic step(input logic [W-1:0] r, input logic rn, input int n);
        for (int c = 0; c < n; c++) begin
            raw   = r;
            rst_n = rn;
            @(posedge clk);
            model_edge(r, rn);
            #1;
        end
    endtask

    // Monitor: outputs are valid every cycle; compare on the falling edge.
    initial begin
        logic [3*W:0] e;
        logic [3*W:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {level, rise, fall, change};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s t=%0t: got level=%b rise=%b fall=%b change=%b, expected level=%b rise=%b fall=%b change=%b",
                             phase, $time, level, rise, fall, change,
                             e[3*W:2*W+1], e[2*W:W+1], e[W:1], e[0]);
                end
                checks++;
                if ((rise & fall) !== '0) begin
                    failures++;
                    $display("FAIL %s rise_fall_overlap t=%0t: rise=%b fall=%b, expected no common bit",
                             phase, $time, rise, fall);
                end
            end
        end
    end

    // Stimulus sequence and final report.
    initial begin
        logic [W-1:0] r;
        logic         rn;
        int           n;

        d0      = '0;
        d1      = '0;
        m_level = '0;

        phase = "reset";
        step(2'b00, 1'b0, 3);
        step(2'b00, 1'b1, 3);

        phase = "clean_step";
        step(2'b01, 1'b1, 10);

        phase = "clean_fall";
        step(2'b00, 1'b1, 10);

        phase = "bounce";
        step(2'b01, 1'b1, 1);
        step(2'b00, 1'b1, 1);
        step(2'b01, 1'b1, 1);
        step(2'b00, 1'b1, 1);
        step(2'b01, 1'b1, 10);

        phase = "short_glitch";
        step(2'b11, 1'b1, 3);
        step(2'b01, 1'b1, 10);

        phase = "simultaneous";
        step(2'b10, 1'b1, 10);

        phase = "reset_mid";
        step(2'b11, 1'b1, 3);
        step(2'b11, 1'b0, 1);
        step(2'b11, 1'b1, 10);

        phase = "random";
        for (int seg = 0; seg < 300; seg++) begin
            r  = W'($urandom_range(0, 3));
            n  = $urandom_range(1, 8);
            rn = ($urandom_range(0, 39) != 0);
            step(r, rn, rn ? n : 1);
        end
        step(r, 1'b1, 8);

        phase = "drain";
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses left unchecked, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
